// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR filter chain.
package fir_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 16;
    localparam int DEFAULT_DECIM_FACTOR = 4;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t data;
        logic    last;
    } axis_beat_t;

    // A 1-state counter still needs one bit to exist.
    function automatic int phase_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_axis_fifo2.sv
// Two-entry AXI-Stream skid buffer; the full flag is decoded from the count register only.
module fir_axis_fifo2 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic                         wr_last,
    output logic                         full,
    output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    beat_t      mem_reg [2];
    beat_t      wr_beat;
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       pop;

    assign wr_beat       = '{data: wr_data, last: wr_last};
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid = (count_reg != 2'd0);
    assign full          = (count_reg == 2'd2);
    assign m_axis_tdata  = mem_reg[rd_ptr_reg].data;
    assign m_axis_tlast  = mem_reg[rd_ptr_reg].last;

    always_comb begin
        count_next = count_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (!wr_en && pop) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (wr_en) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    // Entries are cleared on reset so the idle head presents zero data and tlast.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= wr_beat;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fir_decimator.sv
// Keeps one accepted sample in every DECIM_FACTOR, restarting the phase at each
// frame end and always forwarding tlast samples, through a 2-entry output buffer.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int  DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int  DECIM_FACTOR = DEFAULT_DECIM_FACTOR,
    localparam int PHASE_WIDTH  = phase_width(DECIM_FACTOR)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] s_axis_dec_tdata,
    input  logic                         s_axis_dec_tvalid,
    output logic                         s_axis_dec_tready,
    input  logic                         s_axis_dec_tlast,
    output logic signed [DATA_WIDTH-1:0] m_axis_dec_tdata,
    output logic                         m_axis_dec_tvalid,
    input  logic                         m_axis_dec_tready,
    output logic                         m_axis_dec_tlast
);

    logic [PHASE_WIDTH-1:0] phase_reg;
    logic [PHASE_WIDTH-1:0] phase_next;
    logic                   run_reg;
    logic                   fifo_full;
    logic                   accept;
    logic                   keep;

    // Ready is registered-only so it never follows m_axis_dec_tready in the same cycle,
    // and stays low until the first edge after reset is released.
    assign s_axis_dec_tready = run_reg && !fifo_full;
    assign accept            = s_axis_dec_tvalid && s_axis_dec_tready;
    assign keep              = accept && ((phase_reg == '0) || s_axis_dec_tlast);

    always_comb begin
        phase_next = phase_reg;
        if (accept) begin
            if (s_axis_dec_tlast || (phase_reg == PHASE_WIDTH'(DECIM_FACTOR - 1))) begin
                phase_next = '0;
            end else begin
                phase_next = phase_reg + PHASE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg <= '0;
            run_reg   <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            run_reg   <= 1'b1;
        end
    end

    fir_axis_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (keep),
        .wr_data      (s_axis_dec_tdata),
        .wr_last      (s_axis_dec_tlast),
        .full         (fifo_full),
        .m_axis_tdata (m_axis_dec_tdata),
        .m_axis_tvalid(m_axis_dec_tvalid),
        .m_axis_tready(m_axis_dec_tready),
        .m_axis_tlast (m_axis_dec_tlast)
    );

endmodule
